// File: rtl/lsu_dcache_master.sv
// lsu_dcache_master: single-outstanding load/store master towards the data cache.
// An accepted op is checked for alignment, turned into one word-aligned cache
// request with a byte-lane mask, and the lane-positioned response is shifted
// down and extended. A REQ+RSP watchdog aborts accesses the cache never answers.
module lsu_dcache_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_op_valid,
    output logic        o_op_ready,
    input  logic        i_op_store,
    input  logic [2:0]  i_op_funct3,
    input  logic [31:0] i_op_addr,
    input  logic [31:0] i_op_wdata,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [31:0] o_req_addr,
    output logic [3:0]  o_req_bmsk,
    output logic        o_req_wren,
    output logic [31:0] o_req_data,
    input  logic        i_rsp_valid,
    output logic        o_rsp_ready,
    input  logic [31:0] i_rsp_data,
    output logic        o_res_valid,
    output logic [31:0] o_res_data,
    output logic        o_res_err
);

    // Counter can reach TIMEOUT (handshake on the last REQ cycle), so size for TIMEOUT+1 values.
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_op_ready;
    logic          r_req_valid;
    logic [31:0]   r_req_addr;
    logic [3:0]    r_req_bmsk;
    logic          r_req_wren;
    logic [31:0]   r_req_data;
    logic          r_rsp_ready;
    logic          r_res_valid;
    logic [31:0]   r_res_data;
    logic          r_res_err;
    logic [2:0]    r_funct3;
    logic [1:0]    r_off;

    logic          w_misaligned;
    logic [3:0]    w_bmsk;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_load_res;
    logic          w_timeout;

    // Undefined funct3 encodings are reported the same way as misalignment.
    function automatic logic f_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic bad;
        case (funct3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = off[0];
            3'b010:         bad = (off != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] f_bmsk(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] m;
        case (funct3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // d is already shifted so the addressed byte sits in bits [7:0].
    function automatic logic [31:0] f_extend(input logic [2:0] funct3, input logic [31:0] d);
        logic [31:0] r;
        case (funct3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b100:  r = {24'h000000, d[7:0]};
            3'b101:  r = {16'h0000, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign w_misaligned = f_misaligned(i_op_funct3, i_op_addr[1:0]);
    assign w_bmsk       = f_bmsk(i_op_funct3, i_op_addr[1:0]);
    assign w_wdata_sh   = i_op_wdata << {i_op_addr[1:0], 3'b000};
    assign w_load_res   = f_extend(r_funct3, i_rsp_data >> {r_off, 3'b000});
    assign w_timeout    = (r_cnt >= CNT_LAST);

    // Access FSM: sequences one op through request/response and registers every output.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op_ready  <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_addr  <= 32'h0000_0000;
            r_req_bmsk  <= 4'b0000;
            r_req_wren  <= 1'b0;
            r_req_data  <= 32'h0000_0000;
            r_rsp_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 32'h0000_0000;
            r_res_err   <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_op_valid && r_op_ready) begin
                        r_op_ready <= 1'b0;
                        if (w_misaligned) begin
                            r_state     <= S_DONE;
                            r_res_valid <= 1'b1;
                            r_res_err   <= 1'b1;
                            r_res_data  <= 32'h0000_0000;
                        end else begin
                            r_state     <= S_REQ;
                            r_cnt       <= '0;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= {i_op_addr[31:2], 2'b00};
                            r_req_bmsk  <= w_bmsk;
                            r_req_wren  <= i_op_store;
                            r_req_data  <= w_wdata_sh;
                            r_funct3    <= i_op_funct3;
                            r_off       <= i_op_addr[1:0];
                        end
                    end else begin
                        r_op_ready <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (i_req_ready) begin
                        r_state     <= S_RSP;
                        r_req_valid <= 1'b0;
                        r_rsp_ready <= 1'b1;
                        r_cnt       <= r_cnt + CNT_ONE;
                    end else if (w_timeout) begin
                        r_state     <= S_DONE;
                        r_req_valid <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_res_err   <= 1'b1;
                        r_res_data  <= 32'h0000_0000;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_RSP: begin
                    if (i_rsp_valid) begin
                        r_state     <= S_DONE;
                        r_rsp_ready <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_res_err   <= 1'b0;
                        r_res_data  <= r_req_wren ? 32'h0000_0000 : w_load_res;
                    end else if (w_timeout) begin
                        r_state     <= S_DONE;
                        r_rsp_ready <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_res_err   <= 1'b1;
                        r_res_data  <= 32'h0000_0000;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_res_valid <= 1'b0;
                    r_op_ready  <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_op_ready  <= 1'b0;
                    r_req_valid <= 1'b0;
                    r_rsp_ready <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_op_ready  = r_op_ready;
    assign o_req_valid = r_req_valid;
    assign o_req_addr  = r_req_addr;
    assign o_req_bmsk  = r_req_bmsk;
    assign o_req_wren  = r_req_wren;
    assign o_req_data  = r_req_data;
    assign o_rsp_ready = r_rsp_ready;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_err   = r_res_err;

endmodule

// File: tb/tb_lsu_dcache_master.sv
// tb_lsu_dcache_master: directed and randomized-stall checks of lsu_dcache_master.
// A second instance with TIMEOUT=8 exercises the watchdog; it shares all inputs
// except the op-valid strobe, so it stays idle during the other tests.
module tb_lsu_dcache_master;

    logic        clk = 1'b0;
    logic        i_rstn = 1'b1;
    logic        i_op_valid = 1'b0;
    logic        t_op_valid = 1'b0;
    logic        i_op_store = 1'b0;
    logic [2:0]  i_op_funct3 = 3'b000;
    logic [31:0] i_op_addr = 32'h0;
    logic [31:0] i_op_wdata = 32'h0;
    logic        i_req_ready = 1'b0;
    logic        i_rsp_valid = 1'b0;
    logic [31:0] i_rsp_data = 32'h0;

    logic        o_op_ready, o_req_valid, o_req_wren, o_rsp_ready, o_res_valid, o_res_err;
    logic [31:0] o_req_addr, o_req_data, o_res_data;
    logic [3:0]  o_req_bmsk;
    logic        t_op_ready, t_req_valid, t_req_wren, t_rsp_ready, t_res_valid, t_res_err;
    logic [31:0] t_req_addr, t_req_data, t_res_data;
    logic [3:0]  t_req_bmsk;

    int checks = 0;
    int fails  = 0;

    logic [31:0] cmem [64];
    logic [7:0]  refmem [256];

    always #5 clk = ~clk;

    lsu_dcache_master dut (
        .i_clk(clk), .i_rstn(i_rstn),
        .i_op_valid(i_op_valid), .o_op_ready(o_op_ready),
        .i_op_store(i_op_store), .i_op_funct3(i_op_funct3),
        .i_op_addr(i_op_addr), .i_op_wdata(i_op_wdata),
        .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
        .o_req_addr(o_req_addr), .o_req_bmsk(o_req_bmsk),
        .o_req_wren(o_req_wren), .o_req_data(o_req_data),
        .i_rsp_valid(i_rsp_valid), .o_rsp_ready(o_rsp_ready), .i_rsp_data(i_rsp_data),
        .o_res_valid(o_res_valid), .o_res_data(o_res_data), .o_res_err(o_res_err)
    );

    lsu_dcache_master #(.TIMEOUT(8)) dut8 (
        .i_clk(clk), .i_rstn(i_rstn),
        .i_op_valid(t_op_valid), .o_op_ready(t_op_ready),
        .i_op_store(i_op_store), .i_op_funct3(i_op_funct3),
        .i_op_addr(i_op_addr), .i_op_wdata(i_op_wdata),
        .o_req_valid(t_req_valid), .i_req_ready(i_req_ready),
        .o_req_addr(t_req_addr), .o_req_bmsk(t_req_bmsk),
        .o_req_wren(t_req_wren), .o_req_data(t_req_data),
        .i_rsp_valid(i_rsp_valid), .o_rsp_ready(t_rsp_ready), .i_rsp_data(i_rsp_data),
        .o_res_valid(t_res_valid), .o_res_data(t_res_data), .o_res_err(t_res_err)
    );

    // Drives one op through the main instance with the given stalls; cmem acts as the cache.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int req_stall, input int rsp_stall,
                          output logic got_req, output logic [31:0] q_addr, output logic [3:0] q_bmsk,
                          output logic q_wren, output logic [31:0] q_data,
                          output logic [31:0] res_d, output logic res_e);
        int n;
        int idx;
        logic [31:0] word;
        got_req = 1'b0; q_addr = 32'h0; q_bmsk = 4'h0; q_wren = 1'b0; q_data = 32'h0;
        n = 0;
        while (o_op_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (o_op_ready !== 1'b1) begin fails++; $display("FAIL op_ready_wait: got %b expected 1", o_op_ready); end
        i_op_valid = 1'b1; i_op_store = st; i_op_funct3 = f3; i_op_addr = addr; i_op_wdata = wd;
        @(posedge clk); #1;
        i_op_valid = 1'b0;
        if (o_req_valid === 1'b1) begin
            got_req = 1'b1;
            q_addr = o_req_addr; q_bmsk = o_req_bmsk; q_wren = o_req_wren; q_data = o_req_data;
            for (int k = 0; k < req_stall; k++) begin
                @(posedge clk); #1;
                checks++;
                if ({o_req_valid, o_req_addr, o_req_bmsk, o_req_wren, o_req_data} !== {1'b1, q_addr, q_bmsk, q_wren, q_data}) begin
                    fails++;
                    $display("FAIL req_stable: got v=%b a=%h m=%b w=%b d=%h expected v=1 a=%h m=%b w=%b d=%h",
                             o_req_valid, o_req_addr, o_req_bmsk, o_req_wren, o_req_data, q_addr, q_bmsk, q_wren, q_data);
                end
            end
            i_req_ready = 1'b1;
            @(posedge clk); #1;
            i_req_ready = 1'b0;
            idx = int'(q_addr[7:2]);
            if (q_wren) begin
                for (int b = 0; b < 4; b++) begin
                    if (q_bmsk[b]) cmem[idx][8*b +: 8] = q_data[8*b +: 8];
                end
            end
            word = cmem[idx];
            for (int k = 0; k <= rsp_stall; k++) begin
                checks++;
                if (o_rsp_ready !== 1'b1) begin fails++; $display("FAIL rsp_ready: got %b expected 1", o_rsp_ready); end
                if (k < rsp_stall) begin @(posedge clk); #1; end
            end
            i_rsp_valid = 1'b1;
            i_rsp_data = q_wren ? 32'hA5A5_A5A5 : word;
            @(posedge clk); #1;
            i_rsp_valid = 1'b0;
        end
        checks++;
        if (o_res_valid !== 1'b1) begin fails++; $display("FAIL res_pulse: got %b expected 1", o_res_valid); end
        res_d = o_res_data; res_e = o_res_err;
        @(posedge clk); #1;
        checks++;
        if ({o_res_valid, o_res_data, o_res_err} !== {1'b0, res_d, res_e}) begin
            fails++;
            $display("FAIL res_hold: got v=%b d=%h e=%b expected v=0 d=%h e=%b", o_res_valid, o_res_data, o_res_err, res_d, res_e);
        end
    endtask

    // Outputs are zero while reset is held; op_ready rises on the first edge after release.
    task automatic test_reset();
        #2 i_rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_op_ready, o_req_valid, o_req_addr, o_req_bmsk, o_req_wren, o_req_data, o_rsp_ready, o_res_valid, o_res_data, o_res_err} !== 106'h0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b a=%h m=%b rsp=%b res=%b d=%h e=%b expected all 0",
                     o_op_ready, o_req_valid, o_req_addr, o_req_bmsk, o_rsp_ready, o_res_valid, o_res_data, o_res_err);
        end
        @(negedge clk) i_rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({o_op_ready, t_op_ready} !== 2'b11) begin
            fails++; $display("FAIL reset_release_ready: got %b%b expected 11", o_op_ready, t_op_ready);
        end
    endtask

    task automatic test_store_word();
        logic g, w, e; logic [31:0] a, d, rd; logic [3:0] m;
        run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, g, a, m, w, d, rd, e);
        checks++;
        if ({g, a, m, w, d, rd, e} !== {1'b1, 32'h100, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL sw_0x100: got req=%b a=%h m=%b w=%b d=%h res=%h e=%b expected req=1 a=00000100 m=1111 w=1 d=deadbeef res=0 e=0",
                     g, a, m, w, d, rd, e);
        end
    endtask

    task automatic test_load_byte();
        logic g, w, e; logic [31:0] a, d, rd; logic [3:0] m;
        cmem[0] = 32'h8012_3456;
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 1, 2, g, a, m, w, d, rd, e);
        checks++;
        if ({g, a, m, w, rd, e} !== {1'b1, 32'h100, 4'b1000, 1'b0, 32'hFFFFFF80, 1'b0}) begin
            fails++; $display("FAIL lb_0x103: got a=%h m=%b w=%b res=%h e=%b expected a=00000100 m=1000 w=0 res=ffffff80 e=0", a, m, w, rd, e);
        end
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 1, g, a, m, w, d, rd, e);
        checks++;
        if ({m, rd, e} !== {4'b1000, 32'h00000080, 1'b0}) begin
            fails++; $display("FAIL lbu_0x103: got m=%b res=%h e=%b expected m=1000 res=00000080 e=0", m, rd, e);
        end
        cmem[2] = 32'h0000_7F00;
        run_op(1'b0, 3'b000, 32'h109, 32'h0, 0, 0, g, a, m, w, d, rd, e);
        checks++;
        if ({a, m, rd} !== {32'h108, 4'b0010, 32'h0000007F}) begin
            fails++; $display("FAIL lb_0x109: got a=%h m=%b res=%h expected a=00000108 m=0010 res=0000007f", a, m, rd);
        end
    endtask

    task automatic test_halfword();
        logic g, w, e; logic [31:0] a, d, rd; logic [3:0] m;
        run_op(1'b1, 3'b001, 32'h202, 32'h0000_1234, 2, 0, g, a, m, w, d, rd, e);
        checks++;
        if ({a, m, w, d, rd, e} !== {32'h200, 4'b1100, 1'b1, 32'h12340000, 32'h0, 1'b0}) begin
            fails++; $display("FAIL sh_0x202: got a=%h m=%b w=%b d=%h res=%h e=%b expected a=00000200 m=1100 w=1 d=12340000 res=0 e=0", a, m, w, d, rd, e);
        end
        run_op(1'b0, 3'b101, 32'h202, 32'h0, 0, 3, g, a, m, w, d, rd, e);
        checks++;
        if ({m, rd, e} !== {4'b1100, 32'h00001234, 1'b0}) begin
            fails++; $display("FAIL lhu_0x202: got m=%b res=%h e=%b expected m=1100 res=00001234 e=0", m, rd, e);
        end
        cmem[1] = 32'h8001_0000;
        run_op(1'b0, 3'b001, 32'h206, 32'h0, 0, 0, g, a, m, w, d, rd, e);
        checks++;
        if (rd !== 32'hFFFF8001) begin fails++; $display("FAIL lh_0x206: got %h expected ffff8001", rd); end
    endtask

    // Zero-wait cache: accept N, request N+1, response N+2, result N+3, ready again N+4.
    task automatic test_latency();
        i_req_ready = 1'b1; i_rsp_valid = 1'b1; i_rsp_data = 32'h1122_3344;
        i_op_store = 1'b0; i_op_funct3 = 3'b010; i_op_addr = 32'h104; i_op_valid = 1'b1;
        @(posedge clk); #1; i_op_valid = 1'b0;
        checks++;
        if ({o_req_valid, o_rsp_ready, o_op_ready, o_res_valid} !== 4'b1000) begin
            fails++; $display("FAIL lat_n1: got req/rsp/rdy/res=%b expected 1000", {o_req_valid, o_rsp_ready, o_op_ready, o_res_valid});
        end
        @(posedge clk); #1;
        checks++;
        if ({o_req_valid, o_rsp_ready, o_op_ready, o_res_valid} !== 4'b0100) begin
            fails++; $display("FAIL lat_n2: got req/rsp/rdy/res=%b expected 0100", {o_req_valid, o_rsp_ready, o_op_ready, o_res_valid});
        end
        @(posedge clk); #1;
        checks++;
        if ({o_req_valid, o_rsp_ready, o_op_ready, o_res_valid, o_res_data} !== {4'b0001, 32'h11223344}) begin
            fails++; $display("FAIL lat_n3: got req/rsp/rdy/res=%b d=%h expected 0001 d=11223344", {o_req_valid, o_rsp_ready, o_op_ready, o_res_valid}, o_res_data);
        end
        @(posedge clk); #1;
        i_req_ready = 1'b0; i_rsp_valid = 1'b0;
        checks++;
        if ({o_op_ready, o_res_valid, o_res_data} !== {2'b10, 32'h11223344}) begin
            fails++; $display("FAIL lat_n4: got rdy=%b res=%b d=%h expected rdy=1 res=0 d=11223344", o_op_ready, o_res_valid, o_res_data);
        end
    endtask

    // Reset in REQ (phase 0) and RSP (phase 1): access dropped, no result pulse afterwards.
    task automatic test_reset_mid();
        for (int ph = 0; ph < 2; ph++) begin
            i_op_store = 1'b0; i_op_funct3 = 3'b010; i_op_addr = 32'h80; i_op_valid = 1'b1;
            @(posedge clk); #1; i_op_valid = 1'b0;
            if (ph == 1) begin i_req_ready = 1'b1; @(posedge clk); #1; i_req_ready = 1'b0; end
            checks++;
            if ({o_req_valid, o_rsp_ready} !== ((ph == 0) ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL reset_mid_state%0d: got req/rsp=%b%b", ph, o_req_valid, o_rsp_ready);
            end
            #2 i_rstn = 1'b0;
            #1;
            checks++;
            if ({o_op_ready, o_req_valid, o_req_addr, o_req_bmsk, o_req_wren, o_req_data, o_rsp_ready, o_res_valid, o_res_data, o_res_err} !== 106'h0) begin
                fails++;
                $display("FAIL reset_mid_clear%0d: got rdy=%b rv=%b a=%h m=%b rsp=%b res=%b d=%h e=%b expected all 0",
                         ph, o_op_ready, o_req_valid, o_req_addr, o_req_bmsk, o_rsp_ready, o_res_valid, o_res_data, o_res_err);
            end
            @(negedge clk) i_rstn = 1'b1;
            i_rsp_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                checks++;
                if ({o_res_valid, o_op_ready} !== 2'b01) begin
                    fails++; $display("FAIL reset_mid_nopulse%0d: got res/rdy=%b%b expected 01", ph, o_res_valid, o_op_ready);
                end
            end
            i_rsp_valid = 1'b0;
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
        logic [31:0] ads [4] = '{32'h101, 32'h201, 32'h100, 32'h102};
        logic        sts [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            i_op_store = sts[i]; i_op_funct3 = f3s[i]; i_op_addr = ads[i]; i_op_valid = 1'b1;
            @(posedge clk); #1; i_op_valid = 1'b0;
            checks++;
            if ({o_req_valid, o_res_valid, o_res_err, o_res_data} !== {3'b011, 32'h0}) begin
                fails++; $display("FAIL misaligned%0d: got req=%b res=%b e=%b d=%h expected req=0 res=1 e=1 d=0", i, o_req_valid, o_res_valid, o_res_err, o_res_data);
            end
            @(posedge clk); #1;
            checks++;
            if ({o_req_valid, o_res_valid, o_op_ready, o_res_err} !== 4'b0011) begin
                fails++; $display("FAIL misaligned_after%0d: got req/res/rdy/err=%b expected 0011", i, {o_req_valid, o_res_valid, o_op_ready, o_res_err});
            end
        end
    endtask

    // TIMEOUT=8 instance with a silent cache aborts after 8 REQ cycles; stray response ignored.
    task automatic test_timeout();
        int n;
        i_op_store = 1'b0; i_op_funct3 = 3'b010; i_op_addr = 32'h40; t_op_valid = 1'b1;
        @(posedge clk); #1; t_op_valid = 1'b0;
        n = 0;
        while (t_res_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 8) begin fails++; $display("FAIL timeout_cycles: got %0d expected 8", n); end
        checks++;
        if ({t_res_valid, t_res_err, t_res_data, t_req_valid, t_rsp_ready} !== {2'b11, 32'h0, 2'b00}) begin
            fails++; $display("FAIL timeout_result: got v=%b e=%b d=%h req=%b rsp=%b expected v=1 e=1 d=0 req=0 rsp=0",
                              t_res_valid, t_res_err, t_res_data, t_req_valid, t_rsp_ready);
        end
        i_rsp_valid = 1'b1; i_rsp_data = 32'h1234_5678;
        @(posedge clk); #1;
        checks++;
        if (t_rsp_ready !== 1'b0) begin fails++; $display("FAIL late_rsp_ready: got %b expected 0", t_rsp_ready); end
        @(posedge clk); #1;
        i_rsp_valid = 1'b0;
        checks++;
        if ({t_res_valid, t_res_err, t_res_data, t_op_ready} !== {2'b01, 32'h0, 1'b1}) begin
            fails++; $display("FAIL timeout_hold: got v=%b e=%b d=%h rdy=%b expected v=0 e=1 d=0 rdy=1", t_res_valid, t_res_err, t_res_data, t_op_ready);
        end
    endtask

    // Handshakes on the cycles where the TIMEOUT=8 counter has expired still complete normally.
    task automatic test_handshake_wins();
        i_op_store = 1'b0; i_op_funct3 = 3'b010; i_op_addr = 32'h44; t_op_valid = 1'b1;
        @(posedge clk); #1; t_op_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        i_req_ready = 1'b1;
        @(posedge clk); #1; i_req_ready = 1'b0;
        checks++;
        if ({t_rsp_ready, t_res_valid} !== 2'b10) begin
            fails++; $display("FAIL hs_wins_req: got rsp/res=%b%b expected 10", t_rsp_ready, t_res_valid);
        end
        i_rsp_valid = 1'b1; i_rsp_data = 32'hCAFE_F00D;
        @(posedge clk); #1; i_rsp_valid = 1'b0;
        checks++;
        if ({t_res_valid, t_res_err, t_res_data} !== {2'b10, 32'hCAFEF00D}) begin
            fails++; $display("FAIL hs_wins_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=cafef00d", t_res_valid, t_res_err, t_res_data);
        end
    endtask

    // 1000 mixed aligned ops with 0-7 cycle stalls against a byte-level reference memory.
    task automatic test_random();
        logic [2:0] f3tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic g, w, e, st; logic [31:0] a, d, rd, wd, exp; logic [3:0] m; logic [2:0] f3;
        int sel, sz, ai;
        for (int i = 0; i < 256; i++) refmem[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) cmem[i] = {refmem[4*i+3], refmem[4*i+2], refmem[4*i+1], refmem[4*i]};
        for (int t = 0; t < 1000; t++) begin
            st  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 4));
            if (st && sel > 2) sel = sel - 3;
            f3  = f3tab[sel];
            sz  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
            ai  = int'($urandom_range(0, 255)) & ~(sz - 1);
            wd  = $urandom;
            run_op(st, f3, 32'(ai), wd, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), g, a, m, w, d, rd, e);
            if (st) begin
                for (int b = 0; b < sz; b++) refmem[ai+b] = wd[8*b +: 8];
                exp = 32'h0;
            end else begin
                case (f3)
                    3'b000:  exp = {{24{refmem[ai][7]}}, refmem[ai]};
                    3'b100:  exp = {24'h0, refmem[ai]};
                    3'b001:  exp = {{16{refmem[ai+1][7]}}, refmem[ai+1], refmem[ai]};
                    3'b101:  exp = {16'h0, refmem[ai+1], refmem[ai]};
                    default: exp = {refmem[ai+3], refmem[ai+2], refmem[ai+1], refmem[ai]};
                endcase
            end
            checks++;
            if ({g, rd, e} !== {1'b1, exp, 1'b0}) begin
                fails++;
                $display("FAIL random_op%0d: st=%b f3=%b addr=%h got req=%b res=%h e=%b expected req=1 res=%h e=0", t, st, f3, ai, g, rd, e, exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) cmem[i] = 32'h0;
        test_reset();
        test_store_word();
        test_load_byte();
        test_halfword();
        test_latency();
        test_reset_mid();
        test_misaligned();
        test_timeout();
        test_handshake_wins();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/lsu_dcache_master.md
LSU_DCACHE_MASTER -- requirements
Module: lsu_dcache_master

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of cycles in REQ+RSP before the access is aborted with an error.
REQ-002 i_clk  input  1  clock; i_rstn  input  1  reset, asynchronous, active-low.
REQ-003 i_op_valid  input  1  load/store op offered; o_op_ready  output  1  op accepted when both high.
REQ-004 i_op_store  input  1  1=store, 0=load; i_op_funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-005 i_op_addr  input  32  byte address; i_op_wdata  input  32  store data, LSB-justified.
REQ-006 o_req_valid  output  1  cache request valid; i_req_ready  input  1  cache accepts request.
REQ-007 o_req_addr  output  32  word-aligned address; o_req_bmsk  output  4  byte-lane mask; o_req_wren  output  1  write; o_req_data  output  32  lane-shifted write data.
REQ-008 i_rsp_valid  input  1  cache response valid; o_rsp_ready  output  1  response accepted; i_rsp_data  input  32  lane-positioned read data.
REQ-009 o_res_valid  output  1  one-cycle completion pulse; o_res_data  output  32  extended load result (0 for stores); o_res_err  output  1  misaligned or timeout.

Function
REQ-010 FSM states IDLE, REQ, RSP, DONE shall be used; the reset state is IDLE.
REQ-011 o_op_ready shall be 1 only in IDLE; o_req_valid only in REQ; o_rsp_ready only in RSP; o_res_valid only in DONE.
REQ-012 IDLE: on op handshake, misaligned (H with addr[0]=1, W with addr[1:0]!=0, or undefined funct3) -> DONE with err=1, no cache request; otherwise latch op -> REQ.
REQ-013 REQ: request fields shall be constant while o_req_valid=1; i_req_ready=1 -> RSP.
REQ-014 RSP: i_rsp_valid=1 -> capture data -> DONE; the response shall be consumed for stores too, with data discarded.
REQ-015 DONE lasts exactly one cycle, then -> IDLE; a new op can be accepted at the earliest the cycle after DONE.
REQ-016 o_req_addr = {addr[31:2],2'b00}; o_req_wren = latched store flag.
REQ-017 o_req_bmsk = B:4'b0001<<off, H:4'b0011<<off, W:4'b1111, where off=addr[1:0].
REQ-018 o_req_data = wdata << (8*off); bytes outside the mask are don't-care but driven to the shifted value.
REQ-019 Load result = i_rsp_data >> (8*off), then B/H sign-extended from bit 7/15, BU/HU zero-extended, W unchanged.
REQ-020 Timeout counter: cleared on REQ entry, increments each REQ/RSP cycle; reaching TIMEOUT -> DONE, err=1, o_res_data=0, and later stray responses are ignored (o_rsp_ready=0 outside RSP).
REQ-021 If handshake and timeout occur in the same cycle, the handshake wins.
REQ-022 Minimum latency with a zero-wait cache: op accept cycle N, request N+1, response N+2, o_res_valid N+3.
REQ-023 o_res_data/o_res_err shall hold their value until the next DONE.

Reset
REQ-024 Asserting i_rstn low shall asynchronously force IDLE, clear the counter, and zero all outputs except o_op_ready.
REQ-025 o_op_ready shall be 0 while i_rstn=0 and equal 1 from the first cycle after release.
REQ-026 Reset during REQ or RSP shall abandon the access, with no o_res_valid pulse generated.

Verification
REQ-027 SW addr 0x100 wdata 0xDEADBEEF -> o_req_addr 0x100, bmsk 1111, wren 1, data 0xDEADBEEF; o_res_valid, err 0, data 0.
REQ-028 LB addr 0x103, rsp 0x80xxxxxx -> bmsk 1000, o_res_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-029 SH addr 0x202 wdata 0x1234 -> o_req_addr 0x200, bmsk 1100, data 0x12340000; LHU addr 0x202 rsp 0x12340000 -> 0x00001234.
REQ-030 LW addr 0x101 -> no o_req_valid; o_res_valid with err 1 on the cycle after accept.
REQ-031 TIMEOUT=8, cache never responds -> o_res_err 1 after 8 REQ/RSP cycles; a late i_rsp_valid sees o_rsp_ready 0.
REQ-032 Random i_req_ready/i_rsp_valid stalls (0-7 cycles) over 1000 mixed ops against a byte-memory cache model -> all load results match the reference memory, and request fields are stable while stalled.
